// File: rtl/rng_word_server_if.sv
// Handshake bundle between rng_word_server, the upstream LFSR generator and
// the word consumer. The slave side is the server itself.
interface rng_word_server_if;
  logic         run;
  logic         lfsr_enable;
  logic         lfsr_latch;
  logic [127:0] rng_in;
  logic         rand_valid;
  logic         rand_ready;
  logic [31:0]  rand_data;
  logic         busy;
  logic         health_fail;
  logic [3:0]   fail_cnt;

  modport slave (
    input  run, rng_in, rand_ready,
    output lfsr_enable, lfsr_latch, rand_valid, rand_data, busy, health_fail, fail_cnt
  );

  modport master (
    output run, rng_in, rand_ready,
    input  lfsr_enable, lfsr_latch, rand_valid, rand_data, busy, health_fail, fail_cnt
  );
endinterface

// File: rtl/rng_word_server.sv
// Warms up an upstream LFSR, latches a 128-bit sample, health-checks it and
// serves it as four 32-bit words (low word first) over a valid/ready port.
module rng_word_server #(
  parameter int WARMUP_CYCLES = 16,
  parameter int MAX_FAILS     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  rng_word_server_if.slave bus
);
  localparam logic [7:0] WarmLast = 8'(WARMUP_CYCLES - 1);
  localparam logic [3:0] MaxFails = 4'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_LATCH,
    S_CAPTURE,
    S_SERVE,
    S_FAULT
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   warm_cnt_q, warm_cnt_d;
  logic [3:0]   fail_cnt_q, fail_cnt_d;
  logic [1:0]   idx_q, idx_d;
  logic [127:0] buf_q, buf_d;
  logic [127:0] prev_q, prev_d;
  logic [3:0]   fail_inc;
  logic         sample_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      warm_cnt_q <= '0;
      fail_cnt_q <= '0;
      idx_q      <= '0;
      buf_q      <= '0;
      prev_q     <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      prev_q     <= prev_d;
    end
  end

  // A stuck-at-zero or repeated sample means the generator is not advancing.
  assign sample_bad = (bus.rng_in == '0) || (bus.rng_in == prev_q);
  assign fail_inc   = (fail_cnt_q >= MaxFails) ? MaxFails : fail_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    fail_cnt_d = fail_cnt_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    prev_d     = prev_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d    = S_WARMUP;
          warm_cnt_d = '0;
        end
      end
      S_WARMUP: begin
        warm_cnt_d = warm_cnt_q + 8'd1;
        if (warm_cnt_q == WarmLast) state_d = S_LATCH;
      end
      S_LATCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (sample_bad) begin
          fail_cnt_d = fail_inc;
          warm_cnt_d = '0;
          state_d    = (fail_inc == MaxFails) ? S_FAULT : S_WARMUP;
        end else begin
          buf_d      = bus.rng_in;
          prev_d     = bus.rng_in;
          fail_cnt_d = '0;
          idx_d      = '0;
          state_d    = S_SERVE;
        end
      end
      S_SERVE: begin
        if (bus.rand_ready) begin
          // idx stays at 3 after the last word so rand_data keeps showing it.
          if (idx_q == 2'd3) begin
            warm_cnt_d = '0;
            state_d    = bus.run ? S_WARMUP : S_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.lfsr_enable = (state_q == S_WARMUP) || (state_q == S_LATCH);
  assign bus.lfsr_latch  = (state_q == S_LATCH);
  assign bus.rand_valid  = (state_q == S_SERVE);
  assign bus.rand_data   = buf_q[{idx_q, 5'd0} +: 32];
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign bus.health_fail = (state_q == S_FAULT);
  assign bus.fail_cnt    = fail_cnt_q;
endmodule

// File: tb/tb_rng_word_server.sv
// Randomized self-checking bench for rng_word_server against a word-queue
// model of the accept/reject and serving rules.
module tb_rng_word_server;
  localparam int WARMUP = 16;
  localparam int MAXF   = 3;
  localparam logic [127:0] NOMINAL = 128'h00000004_00000003_00000002_00000001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rng_word_server_if bus();

  rng_word_server #(.WARMUP_CYCLES(WARMUP), .MAX_FAILS(MAXF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last accepted sample, consecutive rejects, pending words.
  logic [127:0] model_prev  = '0;
  int           model_fails = 0;
  logic [31:0]  exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    model_prev  = '0;
    model_fails = 0;
    exp_q.delete();
  endtask

  task automatic wait_latch(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.lfsr_latch !== 1'b1 && n < 400);
  endtask

  // Called while LATCH is visible; presents the sample and advances into CAPTURE.
  task automatic drive_sample(input logic [127:0] s, output bit accepted);
    bus.rng_in = s;
    accepted = (s != '0) && (s != model_prev);
    if (accepted) begin
      model_prev  = s;
      model_fails = 0;
      exp_q.delete();
      for (int k = 0; k < 4; k++) exp_q.push_back(s[32*k +: 32]);
    end else if (model_fails < MAXF) begin
      model_fails++;
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.rand_ready = 1'b0;
    bus.rng_in = '0;
    repeat (3) step();
    n_checks += 7;
    if (bus.lfsr_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got=%b exp=0", bus.lfsr_enable); end
    if (bus.lfsr_latch !== 1'b0) begin n_fail++; $display("FAIL reset_latch got=%b exp=0", bus.lfsr_latch); end
    if (bus.rand_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.rand_valid); end
    if (bus.rand_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus.rand_data); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL reset_health got=%b exp=0", bus.health_fail); end
    if (bus.fail_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_failcnt got=%0d exp=0", bus.fail_cnt); end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_run_busy got=%b exp=0", bus.busy); end
    model_reset();
  endtask

  task automatic test_nominal();
    int n;
    bit acc;
    bus.rand_ready = 1'b1;
    bus.run = 1'b1;
    wait_latch(n);
    n_checks += 2;
    if (n != WARMUP + 1) begin n_fail++; $display("FAIL nominal_latch_delay got=%0d exp=%0d", n, WARMUP + 1); end
    if (bus.lfsr_enable !== 1'b1) begin n_fail++; $display("FAIL nominal_enable_at_latch got=%b exp=1", bus.lfsr_enable); end
    drive_sample(NOMINAL, acc);
    n_checks += 2;
    if (bus.lfsr_enable !== 1'b0 || bus.lfsr_latch !== 1'b0) begin
      n_fail++; $display("FAIL capture_enable_latch got=%b%b exp=00", bus.lfsr_enable, bus.lfsr_latch);
    end
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL capture_busy got=%b exp=1", bus.busy); end
    step();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.rand_valid !== 1'b1 || bus.rand_data !== exp_q[0]) begin
        n_fail++; $display("FAIL nominal_word%0d got=%b/%h exp=1/%h", k, bus.rand_valid, bus.rand_data, exp_q[0]);
      end
      $display("nominal word %0d data=%h", k, bus.rand_data);
      void'(exp_q.pop_front());
      step();
    end
    n_checks += 2;
    if (bus.lfsr_enable !== 1'b1 || bus.rand_valid !== 1'b0) begin
      n_fail++; $display("FAIL nominal_rewarm got en=%b valid=%b exp en=1 valid=0", bus.lfsr_enable, bus.rand_valid);
    end
    if (bus.rand_data !== NOMINAL[127:96]) begin
      n_fail++; $display("FAIL nominal_hold_data got=%h exp=%h", bus.rand_data, NOMINAL[127:96]);
    end
  endtask

  task automatic test_repeat_reject();
    int n;
    bit acc;
    logic [127:0] s;
    wait_latch(n);
    drive_sample(NOMINAL, acc);
    step();
    n_checks += 2;
    if (bus.fail_cnt !== 4'(model_fails)) begin n_fail++; $display("FAIL repeat_failcnt got=%0d exp=%0d", bus.fail_cnt, model_fails); end
    if (bus.rand_valid !== 1'b0 || bus.lfsr_enable !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL repeat_rewarm got valid=%b en=%b busy=%b exp 0/1/1", bus.rand_valid, bus.lfsr_enable, bus.busy);
    end
    wait_latch(n);
    s = {$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1;
    drive_sample(s, acc);
    step();
    n_checks++;
    if (bus.fail_cnt !== 4'(model_fails)) begin n_fail++; $display("FAIL accept_clears_failcnt got=%0d exp=%0d", bus.fail_cnt, model_fails); end
    while (exp_q.size() > 0) begin
      n_checks++;
      if (bus.rand_valid !== 1'b1 || bus.rand_data !== exp_q[0]) begin
        n_fail++; $display("FAIL repeat_serve got=%b/%h exp=1/%h", bus.rand_valid, bus.rand_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      step();
    end
  endtask

  task automatic test_fault();
    int n;
    int bad;
    bit acc;
    for (int i = 0; i < MAXF; i++) begin
      wait_latch(n);
      drive_sample('0, acc);
      step();
      n_checks++;
      if (bus.fail_cnt !== 4'(model_fails)) begin n_fail++; $display("FAIL fault_failcnt%0d got=%0d exp=%0d", i, bus.fail_cnt, model_fails); end
    end
    n_checks += 2;
    if (bus.health_fail !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL fault_flags got health=%b busy=%b exp 1/0", bus.health_fail, bus.busy);
    end
    if (bus.lfsr_enable !== 1'b0 || bus.rand_valid !== 1'b0) begin
      n_fail++; $display("FAIL fault_outputs got en=%b valid=%b exp 0/0", bus.lfsr_enable, bus.rand_valid);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.lfsr_enable !== 1'b0 || bus.lfsr_latch !== 1'b0 || bus.health_fail !== 1'b1 || bus.fail_cnt !== 4'(MAXF)) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL fault_sticky got=%0d bad cycles exp=0", bad); end
    bus.run = 1'b0;
    rst_n = 1'b0;
    step();
    model_reset();
    n_checks++;
    if (bus.health_fail !== 1'b0 || bus.fail_cnt !== 4'd0 || bus.busy !== 1'b0 || bus.lfsr_enable !== 1'b0) begin
      n_fail++; $display("FAIL fault_reset_clear got health=%b cnt=%0d busy=%b en=%b exp 0/0/0/0",
                         bus.health_fail, bus.fail_cnt, bus.busy, bus.lfsr_enable);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_backpressure_run_drop();
    int n;
    int bad;
    bit acc;
    bus.run = 1'b1;
    bus.rand_ready = 1'b1;
    wait_latch(n);
    drive_sample(NOMINAL, acc);
    step();
    n_checks++;
    if (bus.rand_valid !== 1'b1 || bus.rand_data !== exp_q[0]) begin
      n_fail++; $display("FAIL bp_word0 got=%b/%h exp=1/%h", bus.rand_valid, bus.rand_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    step();
    bus.rand_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (bus.rand_valid !== 1'b1 || bus.rand_data !== exp_q[0]) begin
        n_fail++; $display("FAIL bp_hold%0d got=%b/%h exp=1/%h", i, bus.rand_valid, bus.rand_data, exp_q[0]);
      end
    end
    bus.rand_ready = 1'b1;
    bus.run = 1'b0;
    void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (bus.rand_valid !== 1'b1 || bus.rand_data !== exp_q[0]) begin
        n_fail++; $display("FAIL bp_after%0d got=%b/%h exp=1/%h", i, bus.rand_valid, bus.rand_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    step();
    n_checks++;
    if (bus.rand_valid !== 1'b0 || bus.busy !== 1'b0 || bus.lfsr_enable !== 1'b0) begin
      n_fail++; $display("FAIL run_drop_idle got valid=%b busy=%b en=%b exp 0/0/0", bus.rand_valid, bus.busy, bus.lfsr_enable);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.busy !== 1'b0 || bus.lfsr_enable !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL run_drop_stays_idle got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_mid_serve_reset();
    int n;
    bit acc;
    bus.run = 1'b1;
    bus.rand_ready = 1'b1;
    wait_latch(n);
    drive_sample({$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1, acc);
    step();
    void'(exp_q.pop_front());
    step();
    void'(exp_q.pop_front());
    step();
    n_checks++;
    if (bus.rand_valid !== 1'b1 || bus.rand_data !== exp_q[0]) begin
      n_fail++; $display("FAIL midrst_word2 got=%b/%h exp=1/%h", bus.rand_valid, bus.rand_data, exp_q[0]);
    end
    rst_n = 1'b0;
    bus.run = 1'b0;
    step();
    model_reset();
    n_checks++;
    if (bus.rand_valid !== 1'b0 || bus.rand_data !== 32'h0 || bus.fail_cnt !== 4'd0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear got valid=%b data=%h cnt=%0d busy=%b exp 0/0/0/0",
                         bus.rand_valid, bus.rand_data, bus.fail_cnt, bus.busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random_rounds();
    int n;
    int guard;
    bit acc;
    bit rdy;
    logic [127:0] s;
    bus.run = 1'b1;
    for (int r = 0; r < 12; r++) begin
      case ($urandom_range(0, 3))
        0:       s = '0;
        1:       s = model_prev;
        default: s = {$urandom(), $urandom(), $urandom(), $urandom()};
      endcase
      if (model_fails == MAXF - 1) s = {$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1;
      wait_latch(n);
      n_checks++;
      if (bus.lfsr_latch !== 1'b1) begin n_fail++; $display("FAIL rnd_latch_timeout r=%0d got=%b exp=1", r, bus.lfsr_latch); end
      drive_sample(s, acc);
      step();
      n_checks++;
      if (bus.fail_cnt !== 4'(model_fails)) begin n_fail++; $display("FAIL rnd_failcnt r=%0d got=%0d exp=%0d", r, bus.fail_cnt, model_fails); end
      guard = 0;
      while (acc && exp_q.size() > 0 && guard < 100) begin
        n_checks++;
        if (bus.rand_valid !== 1'b1 || bus.rand_data !== exp_q[0]) begin
          n_fail++; $display("FAIL rnd_word r=%0d got=%b/%h exp=1/%h", r, bus.rand_valid, bus.rand_data, exp_q[0]);
        end
        rdy = 1'($urandom_range(0, 1));
        bus.rand_ready = rdy;
        if (rdy) $display("round %0d word data=%h", r, bus.rand_data);
        step();
        if (rdy) void'(exp_q.pop_front());
        guard++;
      end
      n_checks++;
      if (guard >= 100 || bus.rand_valid !== 1'b0) begin
        n_fail++; $display("FAIL rnd_end r=%0d got valid=%b guard=%0d exp valid=0", r, bus.rand_valid, guard);
      end
    end
    bus.run = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_repeat_reject();
    test_fault();
    test_backpressure_run_drop();
    test_mid_serve_reset();
    test_random_rounds();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rng_word_server.md
RNG_WORD_SERVER -- requirements
Module: rng_word_server

Interface
REQ-001 Parameter WARMUP_CYCLES, default 16: cycles lfsr_enable is held high before each latch request; legal range 1..255.
REQ-002 Parameter MAX_FAILS, default 3: consecutive rejected samples that trigger a permanent fault; legal range 1..15.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 run  input  1  level; permits the block to start a new warmup from IDLE.
REQ-006 lfsr_enable  output  1  drives the upstream generator's enable.
REQ-007 lfsr_latch  output  1  one-cycle pulse; drives the upstream generator's latch.
REQ-008 rng_in  input  128  registered sample from the upstream generator; valid the cycle after lfsr_latch.
REQ-009 rand_valid  output  1  rand_data holds a word.
REQ-010 rand_ready  input  1  consumer accepts; a transfer occurs when rand_valid and rand_ready are both high on a rising edge.
REQ-011 rand_data  output  32  served random word.
REQ-012 busy  output  1  high in every state except IDLE and FAULT.
REQ-013 health_fail  output  1  sticky fault flag.
REQ-014 fail_cnt  output  4  current consecutive-reject count.

Function
REQ-015 The FSM SHALL have states IDLE, WARMUP, LATCH, CAPTURE, SERVE and FAULT.
REQ-016 IDLE: when run=1, go to WARMUP and clear the warmup counter; otherwise stay in IDLE.
REQ-017 WARMUP: lfsr_enable=1; the counter increments each cycle; after exactly WARMUP_CYCLES cycles in WARMUP, go to LATCH.
REQ-018 LATCH: lfsr_latch=1 and lfsr_enable=1 for exactly one cycle; then go to CAPTURE.
REQ-019 CAPTURE: lfsr_enable=0; rng_in is sampled this cycle, which is the cycle after lfsr_latch.
REQ-020 A sample SHALL be rejected if it equals 128'h0 or equals the previously accepted sample.
REQ-021 Reject path: increment fail_cnt; if the new count equals MAX_FAILS, go to FAULT; otherwise go to WARMUP.
REQ-022 Accept path: store the sample in the word buffer; copy it into the previous-sample register; clear fail_cnt; clear the word index to 0; go to SERVE.
REQ-023 SERVE: rand_valid=1 and rand_data = buffer[32*idx+31 : 32*idx]; idx 0 is served first (bits 31:0), idx 3 last (bits 127:96).
REQ-024 While rand_valid=1 and rand_ready=0, rand_data and rand_valid SHALL remain stable.
REQ-025 On each transfer, idx increments; the transfer at idx=3 SHALL drop rand_valid on the next cycle.
REQ-026 After the idx=3 transfer, go to WARMUP if run=1, otherwise go to IDLE.
REQ-027 rand_ready held high SHALL give one word per cycle; four words take four consecutive cycles.
REQ-028 lfsr_enable SHALL be 0 in IDLE, CAPTURE, SERVE and FAULT.
REQ-029 Deasserting run during WARMUP, LATCH, CAPTURE or SERVE has no effect; run is sampled only in IDLE and at the end of SERVE.
REQ-030 FAULT: set health_fail=1; rand_valid=0; lfsr_enable=0; lfsr_latch=0; remain in FAULT until reset.
REQ-031 fail_cnt SHALL saturate at MAX_FAILS and never wrap.
REQ-032 rand_data SHALL hold its last value when rand_valid=0.
REQ-033 Latency from run=1 in IDLE to the first rand_valid=1 is WARMUP_CYCLES+3 cycles, assuming the sample is accepted.

Reset
REQ-034 When rst_n=0 at a rising edge, the block SHALL go to IDLE.
REQ-035 Reset values: lfsr_enable=0, lfsr_latch=0, rand_valid=0, rand_data=32'h0, busy=0, health_fail=0, fail_cnt=0; buffer, previous sample, idx and warmup counter all 0.
REQ-036 Reset asserted mid-operation (any state, including FAULT or SERVE with a pending word) SHALL take effect at the next edge; the pending word is discarded.

Verification
REQ-037 Nominal: WARMUP_CYCLES=16, run=1, rng_in=128'h00000004_00000003_00000002_00000001 at CAPTURE, rand_ready=1 -> lfsr_latch pulses 17 cycles after run; rand_data sequence is 1, 2, 3, 4 on consecutive cycles; lfsr_enable returns high the cycle after the last word.
REQ-038 Backpressure: rand_ready=0 for 5 cycles at idx=1 -> rand_data is held at 32'h2 with rand_valid=1 for all 5 cycles; no word is lost or duplicated.
REQ-039 Repeat rejection: two consecutive captures of the same 128-bit value -> the second capture is rejected, fail_cnt=1, no rand_valid, and a new WARMUP starts.
REQ-040 Fault: MAX_FAILS=3 and rng_in=0 for 3 captures -> fail_cnt=3, health_fail=1, busy=0, lfsr_enable=0 permanently; a subsequent rst_n low pulse clears all of these.
REQ-041 Run drop: run deasserted during SERVE -> all 4 words are still delivered, then the block enters IDLE with busy=0 and lfsr_enable=0.
REQ-042 Mid-serve reset: rst_n=0 at idx=2 -> the next cycle shows rand_valid=0, rand_data=0, fail_cnt=0, state IDLE.
